// File: rtl/regfile_pkg.sv
// Shared constants and types for the AArch64 integer register file.
package regfile_pkg;
  localparam int XLEN       = 64;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int XZR_IDX    = 31;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xword_t;
endpackage

// File: rtl/regfile_write_bank_decoder.sv
// One-hot write-address decoder: a binary tree of 1:2 enable splitters,
// mirroring the shape of the read-side selector trees.
module decoder_1_2 (
  input  logic       en,
  input  logic       sel,
  output logic [1:0] out
);
  assign out[0] = en & ~sel;
  assign out[1] = en &  sel;
endmodule

module decoder_5_32 (
  input  logic        en,
  input  logic [4:0]  sel,
  output logic [31:0] out
);
  // Heap-ordered tree: node k feeds 2k+1 (sel bit 0) and 2k+2 (sel bit 1);
  // the 32 leaves (nodes 31..62) land in address order.
  logic [62:0] w_node;

  assign w_node[0] = en;

  for (genvar k = 0; k < 31; k++) begin : g_node
    localparam int LVL = $clog2(k + 2) - 1;
    decoder_1_2 u_dec (
      .en  (w_node[k]),
      .sel (sel[4-LVL]),
      .out (w_node[2*k+2:2*k+1])
    );
  end

  assign out = w_node[62:31];
endmodule

// File: rtl/regfile_write_bank.sv
// Write side of the 32 x 64-bit integer register file; X31 (XZR) reads as zero
// and has no storage.
module regfile_write_bank
  import regfile_pkg::*;
(
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               wr_en,
  input  reg_addr_t                          wr_addr,
  input  xword_t                             wr_data,
  output logic [NUM_REGS-1:0][XLEN-1:0]      regs_out,
  output logic [NUM_REGS-1:0]                written,
  output logic [NUM_REGS-1:0]                wr_onehot
);
  logic [NUM_REGS-1:0] w_dec;
  xword_t              r_regs [XZR_IDX];
  logic [XZR_IDX-1:0]  r_written;
  logic [NUM_REGS-1:0] r_onehot;

  decoder_5_32 u_decoder (
    .en  (wr_en),
    .sel (wr_addr),
    .out (w_dec)
  );

  for (genvar i = 0; i < XZR_IDX; i++) begin : g_reg
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_regs[i]    <= '0;
        r_written[i] <= 1'b0;
      end else if (w_dec[i]) begin
        r_regs[i]    <= wr_data;
        r_written[i] <= 1'b1;
      end
    end
    assign regs_out[i] = r_regs[i];
  end

  // XZR: writes are decoded (visible in wr_onehot) but discarded.
  assign regs_out[XZR_IDX] = '0;
  assign written           = {1'b1, r_written};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_onehot <= '0;
    else          r_onehot <= w_dec;
  end

  assign wr_onehot = r_onehot;
endmodule

// File: tb/tb_regfile_write_bank.sv
// Directed self-checking bench for regfile_write_bank.
module tb_regfile_write_bank;
  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   wr_en;
  logic [4:0]             wr_addr;
  logic [63:0]            wr_data;
  logic [31:0][63:0]      regs_out;
  logic [31:0]            written;
  logic [31:0]            wr_onehot;

  logic [31:0][63:0]      exp_regs;
  int checks   = 0;
  int failures = 0;

  regfile_write_bank dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .regs_out  (regs_out),
    .written   (written),
    .wr_onehot (wr_onehot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bank(input string tag);
    for (int i = 0; i < 32; i++)
      chk($sformatf("%s_reg%0d", tag, i), regs_out[i], exp_regs[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_regs = '0;
    reset_n  = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = 'x;
    wr_data  = 'x;
    #2;
    chk("in_reset_written", {32'h0, written}, 64'h8000_0000);
    chk("in_reset_onehot", {32'h0, wr_onehot}, 64'h0);
    tick();
    reset_n = 1'b1;

    // idle with X on the address while disabled
    repeat (3) tick();
    chk_bank("idle");
    chk("idle_written", {32'h0, written}, 64'h8000_0000);
    chk("idle_onehot", {32'h0, wr_onehot}, 64'h0);

    // write X5
    wr_en   = 1'b1;
    wr_addr = 5'd5;
    wr_data = 64'hDEAD_BEEF_0123_4567;
    #1;
    chk("x5_before_edge", regs_out[5], 64'h0);
    chk("x5_written_before", {32'h0, written}, 64'h8000_0000);
    tick();
    exp_regs[5] = 64'hDEAD_BEEF_0123_4567;
    chk("x5_value", regs_out[5], 64'hDEAD_BEEF_0123_4567);
    chk("x5_written", {32'h0, written}, 64'h8000_0020);
    chk("x5_onehot", {32'h0, wr_onehot}, 64'h0000_0020);
    chk_bank("after_x5");

    // write XZR
    wr_addr = 5'd31;
    wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    chk("xzr_value", regs_out[31], 64'h0);
    chk("xzr_written", {32'h0, written}, 64'h8000_0020);
    chk("xzr_onehot", {32'h0, wr_onehot}, 64'h8000_0000);
    chk_bank("after_xzr");

    // back-to-back X7, then a disabled cycle
    wr_addr = 5'd7;
    wr_data = 64'd1;
    tick();
    chk("x7_first", regs_out[7], 64'd1);
    chk("x7_first_onehot", {32'h0, wr_onehot}, 64'h0000_0080);
    wr_data = 64'd2;
    tick();
    chk("x7_second", regs_out[7], 64'd2);
    wr_en   = 1'b0;
    wr_data = 64'd3;
    tick();
    exp_regs[7] = 64'd2;
    chk("x7_hold", regs_out[7], 64'd2);
    chk("x7_idle_onehot", {32'h0, wr_onehot}, 64'h0);
    chk("x7_written", {32'h0, written}, 64'h8000_00A0);

    // sweep 0..30
    wr_en = 1'b1;
    for (int i = 0; i < 31; i++) begin
      wr_addr = 5'(i);
      wr_data = 64'(i + 100);
      tick();
      exp_regs[i] = 64'(i + 100);
      chk($sformatf("sweep_x%0d", i), regs_out[i], 64'(i + 100));
      chk($sformatf("sweep_onehot%0d", i), {32'h0, wr_onehot}, 64'(32'h1 << i));
    end
    chk_bank("sweep");
    chk("sweep_written", {32'h0, written}, 64'hFFFF_FFFF);

    // asynchronous reset in the middle of a write to X3
    wr_addr = 5'd3;
    wr_data = 64'd9;
    #2;
    reset_n = 1'b0;
    #1;
    exp_regs = '0;
    chk_bank("async_rst");
    chk("async_rst_written", {32'h0, written}, 64'h8000_0000);
    chk("async_rst_onehot", {32'h0, wr_onehot}, 64'h0);
    tick();
    chk("rst_held_x3", regs_out[3], 64'h0);
    wr_en = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
    chk("post_rst_x3", regs_out[3], 64'h0);
    chk("post_rst_written", {32'h0, written}, 64'h8000_0000);
    chk("post_rst_onehot", {32'h0, wr_onehot}, 64'h0);

    // first write after deassertion lands on the first edge
    wr_en   = 1'b1;
    wr_addr = 5'd3;
    wr_data = 64'd9;
    tick();
    chk("first_write_x3", regs_out[3], 64'd9);
    chk("first_write_written", {32'h0, written}, 64'h8000_0008);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_write_bank.md
# regfile_write_bank

Write side of the 32-entry AArch64 integer register file: a 5:32 write-address decoder plus 32 x 64-bit flip-flop registers. Accepts one write per clock, gates it through the one-hot decoder, and drives all register contents as a flat bus to the read-port selector trees. Register 31 (XZR) is hardwired to zero. A per-register written-since-reset bitmap supports the hazard and debug logic.

## Interface
- `NUM_REGS`, 32: register count; fixed by the 5-bit address.
- `XLEN`, 64: register width in bits.
- `clk  input  1`: single clock; all state updates on the rising edge.
- `reset_n  input  1`: asynchronous, active-low reset.
- `wr_en  input  1`: write request this cycle.
- `wr_addr  input  5`: destination register index.
- `wr_data  input  XLEN`: write data.
- `regs_out  output  [NUM_REGS-1:0][XLEN-1:0]`: registered contents of every register, fed to the read-port selectors.
- `written  output  NUM_REGS`: bit i = register i written since reset.
- `wr_onehot  output  NUM_REGS`: registered copy of the decoded enable of the last accepted write, for debug and trace.

## Operation
- Decoder: `dec[i] = wr_en && (wr_addr == i)`; exactly one bit is high when `wr_en`=1, and all bits are 0 otherwise.
- Registers 0..30: on a rising edge with `dec[i]`=1, load `wr_data` into register i; otherwise hold.
- Register 31 (XZR): its `regs_out` slice is the constant 0 at all times. A write to 31 is accepted and discarded; no storage is implemented.
- `written[i]`: set on a clock edge where `dec[i]`=1 for i in 0..30, and never cleared except by reset. `written[31]` is constant 1, because XZR always holds a defined value.
- `wr_onehot`: loads `dec` on every clock edge, including all-zero when `wr_en`=0.
- All 64 bits are written together; there are no partial or byte writes. Zero extension of W-register results is the writer's job.
- Reset (`reset_n`=0, asynchronous): all registers 0, `written` = 32'h8000_0000, `wr_onehot` = 0. All outputs take these values immediately on assertion, independent of `clk`.
- Reset deassertion: the first write takes effect on the first rising edge where `reset_n`=1.
- Reset asserted during a write cycle: the reset wins and the write is lost.
- X/Z on `wr_addr` while `wr_en`=0 must not corrupt any state.

## Timing
- Write latency: 1 cycle. Data presented at edge N appears on `regs_out` after edge N.
- A read of the same register in the cycle of the write sees the old value. Write-to-read forwarding belongs to the pipeline, not to this block.
- Back-to-back writes to the same register: the last one wins, one per cycle.
- There is no handshake; the block always accepts a write and never stalls.
- `regs_out`, `written` and `wr_onehot` are driven directly from flops, with no combinational path from the inputs, except the constant XZR slice.

## Structure
- `regfile_pkg`: `XLEN=64`, `NUM_REGS=32`, `REG_ADDR_W=5`, `XZR_IDX=31`, `typedef logic [REG_ADDR_W-1:0] reg_addr_t`, `typedef logic [XLEN-1:0] xword_t`.
- Sub-module `decoder_5_32`:
  - ports `en`, `sel[4:0]`, `out[31:0]`;
  - built as a tree of `decoder_1_2` stages, mirroring the read-side selector tree;
  - purely combinational.
- Storage: a generate loop over i = 0..30 of enabled 64-bit registers, plus a tie-off for index 31.

## Test plan
- Reset, then idle 3 cycles:
  - all `regs_out` = 0;
  - `written` = 32'h8000_0000;
  - `wr_onehot` = 0.
- Write X5 = 64'hDEAD_BEEF_0123_4567:
  - unchanged before the edge;
  - after the edge: `regs_out[5]` matches the written value, `written[5]`=1, `wr_onehot` = 32'h0000_0020;
  - all other registers remain 0.
- Write X31 = 64'hFFFF_FFFF_FFFF_FFFF:
  - `regs_out[31]` remains 0;
  - `written` is unchanged;
  - `wr_onehot` = 32'h8000_0000.
- Back-to-back writes X7 = 1, then X7 = 2, then `wr_en`=0 with `wr_addr`=7 and data 3:
  - `regs_out[7]` shows 1, then 2, then holds 2.
- Sweep i = 0..30 writing the value i+100:
  - each register holds i+100;
  - `written` = 32'hFFFF_FFFF.
- Assert `reset_n` asynchronously mid-cycle during a write to X3 = 9:
  - all outputs return to reset values without waiting for a clock edge;
  - X3 = 0 after deassertion.
